// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- memory-access stage of the 5-stage pipeline.
//
// Sits between the EX/MEM register and WB and owns the MEM/WB register.
// Non-memory instructions pass through in one cycle. Aligned loads and stores
// are issued on a req/ack data-memory bus. The stage stalls upstream until
// the bus acknowledges the access or the optional timeout expires.
// Misaligned accesses are dropped and reported with a one-cycle pulse.
//
// Parameters
//   TIMEOUT  BUS cycles without dm_ack before abort (0 = never abort)
//   TO_W     timeout counter width, TIMEOUT < 2**TO_W
//
// Ports
//   clk, reset                 clock (rising edge), async active-low reset
//   ex_*                       EX/MEM register contents
//   dm_req/we/addr/be/wdata    data-memory request (held stable until ack)
//   dm_ack, dm_rdata           data-memory completion and read word
//   mem_stall                  high for every cycle spent in BUS
//   wb_RFWe/rfwaddr/rfwdata    MEM/WB register towards writeback
//   mem_misalign, mem_timeout  one-cycle fault pulses
// -----------------------------------------------------------------------------
module mem_stage #(
   parameter int TIMEOUT = 0,
   parameter int TO_W    = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic        ex_MemRead,
   input  logic        ex_MemWrite,
   input  logic [2:0]  ex_DMType,
   input  logic [1:0]  ex_WDSel,
   input  logic        ex_RFWe,
   input  logic [4:0]  ex_rfwaddr,
   input  logic [31:0] ex_aluout,
   input  logic [31:0] ex_rs2data,
   input  logic [31:0] ex_pc4,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_wdata,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic        mem_stall,
   output logic        wb_RFWe,
   output logic [4:0]  wb_rfwaddr,
   output logic [31:0] wb_rfwdata,
   output logic        mem_misalign,
   output logic        mem_timeout
);

   typedef enum logic {IDLE = 1'b0, BUS = 1'b1} state_t;

   localparam logic [2:0] DM_WORD   = 3'b000;
   localparam logic [2:0] DM_HALF   = 3'b001;
   localparam logic [2:0] DM_HALF_U = 3'b010;
   localparam logic [2:0] DM_BYTE   = 3'b011;
   localparam logic [2:0] DM_BYTE_U = 3'b100;

   localparam logic [1:0] WD_MEM = 2'b01;
   localparam logic [1:0] WD_PC4 = 2'b10;

   // Last counter value before abort; only used when TIMEOUT > 0.
   localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   // ---------------------------------------------------------------------------
   // State and captured access context
   // ---------------------------------------------------------------------------
   state_t          state, nxt_state;
   logic [TO_W-1:0] to_cnt, nxt_cnt;
   logic [2:0]      cap_type, nxt_cap_type;
   logic [1:0]      cap_lane, nxt_cap_lane;
   logic [1:0]      cap_wdsel, nxt_cap_wdsel;
   logic            cap_rfwe, nxt_cap_rfwe;
   logic [4:0]      cap_rfwaddr, nxt_cap_rfwaddr;
   logic [31:0]     cap_val, nxt_cap_val;

   logic            nxt_req, nxt_we;
   logic [31:0]     nxt_addr, nxt_wdata;
   logic [3:0]      nxt_be;
   logic            nxt_wb_rfwe;
   logic [4:0]      nxt_wb_rfwaddr;
   logic [31:0]     nxt_wb_rfwdata;
   logic            nxt_misalign, nxt_timeout;

   // ---------------------------------------------------------------------------
   // Decode of the instruction waiting in EX/MEM
   // ---------------------------------------------------------------------------
   logic        is_mem, is_byte, is_half, is_word, misaligned;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [31:0] direct_val;

   assign is_mem  = ex_MemRead | ex_MemWrite;
   assign is_byte = (ex_DMType == DM_BYTE) || (ex_DMType == DM_BYTE_U);
   assign is_half = (ex_DMType == DM_HALF) || (ex_DMType == DM_HALF_U);
   // Undefined type codes fall back to a full word access.
   assign is_word = !is_byte && !is_half;

   assign misaligned = (is_half && ex_aluout[0]) ||
                       (is_word && (ex_aluout[1:0] != 2'b00));

   // Value written back when the result does not come from memory.
   assign direct_val = (ex_WDSel == WD_PC4) ? ex_pc4 : ex_aluout;

   always_comb begin
      // NOTE: every combinational output gets a default before any branch;
      // a path that leaves a variable unassigned would infer a latch.
      st_be    = 4'b1111;
      st_wdata = ex_rs2data;
      if (is_byte) begin
         st_be    = 4'b0001 << ex_aluout[1:0];
         st_wdata = {4{ex_rs2data[7:0]}};
      end else if (is_half) begin
         st_be    = ex_aluout[1] ? 4'b1100 : 4'b0011;
         st_wdata = {2{ex_rs2data[15:0]}};
      end
   end

   // ---------------------------------------------------------------------------
   // Load formatting from the captured type and lane
   // ---------------------------------------------------------------------------
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_fmt;

   assign ld_byte = dm_rdata[{cap_lane, 3'b000} +: 8];
   assign ld_half = dm_rdata[{cap_lane[1], 4'b0000} +: 16];

   always_comb begin
      ld_fmt = dm_rdata;
      unique case (cap_type)
         DM_BYTE:   ld_fmt = {{24{ld_byte[7]}}, ld_byte};
         DM_BYTE_U: ld_fmt = {24'h0, ld_byte};
         DM_HALF:   ld_fmt = {{16{ld_half[15]}}, ld_half};
         DM_HALF_U: ld_fmt = {16'h0, ld_half};
         default:   ld_fmt = dm_rdata;
      endcase
   end

   // Stall is a pure decode of the state register.
   assign mem_stall = (state == BUS);

   // ---------------------------------------------------------------------------
   // Next-state and next-register logic
   // ---------------------------------------------------------------------------
   always_comb begin
      nxt_state       = state;
      nxt_cnt         = to_cnt;
      nxt_req         = dm_req;
      nxt_we          = dm_we;
      nxt_addr        = dm_addr;
      nxt_be          = dm_be;
      nxt_wdata       = dm_wdata;
      nxt_cap_type    = cap_type;
      nxt_cap_lane    = cap_lane;
      nxt_cap_wdsel   = cap_wdsel;
      nxt_cap_rfwe    = cap_rfwe;
      nxt_cap_rfwaddr = cap_rfwaddr;
      nxt_cap_val     = cap_val;
      // WB register carries a bubble unless a result is written this edge.
      nxt_wb_rfwe     = 1'b0;
      nxt_wb_rfwaddr  = wb_rfwaddr;
      nxt_wb_rfwdata  = wb_rfwdata;
      nxt_misalign    = 1'b0;
      nxt_timeout     = 1'b0;

      unique case (state)
         IDLE: begin
            if (ex_valid) begin
               if (!is_mem) begin
                  nxt_wb_rfwe    = ex_RFWe;
                  nxt_wb_rfwaddr = ex_rfwaddr;
                  nxt_wb_rfwdata = direct_val;
               end else if (misaligned) begin
                  nxt_misalign = 1'b1;
               end else begin
                  nxt_req         = 1'b1;
                  nxt_we          = ex_MemWrite;
                  nxt_addr        = {ex_aluout[31:2], 2'b00};
                  nxt_be          = st_be;
                  nxt_wdata       = st_wdata;
                  nxt_cap_type    = ex_DMType;
                  nxt_cap_lane    = ex_aluout[1:0];
                  nxt_cap_wdsel   = ex_WDSel;
                  // A store never writes the register file, even if flagged.
                  nxt_cap_rfwe    = ex_RFWe & ~ex_MemWrite;
                  nxt_cap_rfwaddr = ex_rfwaddr;
                  nxt_cap_val     = direct_val;
                  nxt_cnt         = '0;
                  nxt_state       = BUS;
               end
            end
         end

         BUS: begin
            // An ack on the would-be timeout cycle wins over the abort.
            if (dm_ack) begin
               nxt_req        = 1'b0;
               nxt_wb_rfwe    = cap_rfwe;
               nxt_wb_rfwaddr = cap_rfwaddr;
               nxt_wb_rfwdata = (cap_wdsel == WD_MEM) ? ld_fmt : cap_val;
               nxt_cnt        = '0;
               nxt_state      = IDLE;
            end else if ((TIMEOUT > 0) && (to_cnt == TO_LAST)) begin
               nxt_req     = 1'b0;
               nxt_timeout = 1'b1;
               nxt_cnt     = '0;
               nxt_state   = IDLE;
            end else begin
               nxt_cnt = to_cnt + 1'b1;
            end
         end

         default: nxt_state = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         to_cnt       <= '0;
         dm_req       <= 1'b0;
         dm_we        <= 1'b0;
         dm_addr      <= '0;
         dm_be        <= '0;
         dm_wdata     <= '0;
         cap_type     <= '0;
         cap_lane     <= '0;
         cap_wdsel    <= '0;
         cap_rfwe     <= 1'b0;
         cap_rfwaddr  <= '0;
         cap_val      <= '0;
         wb_RFWe      <= 1'b0;
         wb_rfwaddr   <= '0;
         wb_rfwdata   <= '0;
         mem_misalign <= 1'b0;
         mem_timeout  <= 1'b0;
      end else begin
         state        <= nxt_state;
         to_cnt       <= nxt_cnt;
         dm_req       <= nxt_req;
         dm_we        <= nxt_we;
         dm_addr      <= nxt_addr;
         dm_be        <= nxt_be;
         dm_wdata     <= nxt_wdata;
         cap_type     <= nxt_cap_type;
         cap_lane     <= nxt_cap_lane;
         cap_wdsel    <= nxt_cap_wdsel;
         cap_rfwe     <= nxt_cap_rfwe;
         cap_rfwaddr  <= nxt_cap_rfwaddr;
         cap_val      <= nxt_cap_val;
         wb_RFWe      <= nxt_wb_rfwe;
         wb_rfwaddr   <= nxt_wb_rfwaddr;
         wb_rfwdata   <= nxt_wb_rfwdata;
         mem_misalign <= nxt_misalign;
         mem_timeout  <= nxt_timeout;
      end
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage pipeline; sits between the EX/MEM register and WB, and owns the MEM/WB pipeline register that drives WB.
- Issues load/store requests on a req/ack data-memory bus, generates byte enables and aligned store data, and sign/zero-extends load data.
- Selects the writeback value and stalls upstream while a bus access is outstanding.

Parameters:
- TIMEOUT, 0, cycles in BUS without dm_ack before abort; 0 disables the timeout.
- TO_W, 8, timeout counter width; TIMEOUT must be < 2**TO_W.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX/MEM holds a valid instruction.
- ex_MemRead  in  1  load.
- ex_MemWrite  in  1  store; wins if both are set.
- ex_DMType  in  3  000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned.
- ex_WDSel  in  2  writeback select: 00 ALU, 01 memory, 10 pc+4.
- ex_RFWe  in  1  register write enable.
- ex_rfwaddr  in  5  destination register.
- ex_aluout  in  32  ALU result / effective address.
- ex_rs2data  in  32  store data.
- ex_pc4  in  32  pc+4.
- dm_req  out  1  bus request.
- dm_we  out  1  write strobe.
- dm_addr  out  32  word address, bits[1:0]=00.
- dm_be  out  4  byte enables.
- dm_wdata  out  32  lane-aligned store data.
- dm_ack  in  1  access complete; dm_rdata valid on a load.
- dm_rdata  in  32  read word.
- mem_stall  out  1  upstream holds EX/MEM.
- wb_RFWe  out  1  to WB.
- wb_rfwaddr  out  5  to WB.
- wb_rfwdata  out  32  to WB.
- mem_misalign  out  1  one-cycle fault pulse.
- mem_timeout  out  1  one-cycle fault pulse.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=IDLE;
  - every output and the timeout counter to 0, including dm_req, mem_stall, wb_RFWe, the pulses, and all data/addr/be outputs;
  - an in-flight access is dropped, with no writeback and no fault.
- States are IDLE and BUS. mem_stall = (state==BUS), decoded from state only.

IDLE, on each edge (fault pulses default to 0):
- ex_valid=0: WB register loads a bubble (wb_RFWe=0).
- Valid, non-memory op:
  - wb_RFWe=ex_RFWe, wb_rfwaddr=ex_rfwaddr;
  - wb_rfwdata = ex_pc4 if WDSel=10, else ex_aluout;
  - latency 1 cycle.
- Valid, misaligned memory op:
  - misaligned means half with addr[0]=1, or word with addr[1:0]!=0;
  - no bus access; wb_RFWe=0; mem_misalign=1 for one cycle; stay IDLE.
- Valid, aligned memory op:
  - register dm_req=1, dm_we=ex_MemWrite, dm_addr={addr[31:2],2'b00}, dm_be, dm_wdata, plus the load type, lane and dest fields;
  - wb_RFWe=0; go to BUS; counter=0.
- Store byte enables and data:
  - byte: be=0001<<addr[1:0], wdata={4{rs2[7:0]}};
  - half: be=0011<<(2*addr[1]), wdata={2{rs2[15:0]}};
  - word: be=1111, wdata=rs2.

BUS:
- EX inputs are ignored; request outputs are held stable until acknowledged.
- On an edge with dm_ack=1:
  - dm_req=0; go to IDLE;
  - wb_RFWe=captured RFWe (a store sets 0);
  - wb_rfwdata = the formatted load if WDSel=01, else the captured ALU/pc+4 value.
- Load format:
  - byte lane = addr[1:0]; half lane = addr[1];
  - signed types sign-extend from bit 7/15, unsigned types zero-extend; word passes through.
- Minimum memory-op latency is 2 cycles (ack in the first BUS cycle). mem_stall is high for every BUS cycle.
- TIMEOUT>0 and counter==TIMEOUT-1 with no ack:
  - abort: dm_req=0, IDLE, wb_RFWe=0, mem_timeout=1 for one cycle.
  - Otherwise the counter increments each BUS cycle.
- dm_ack in IDLE is ignored. An ack on the timeout cycle counts as completion; the timeout is not raised.

Test Plan:
- Non-memory op: ALU op with aluout=0x1234, rfwaddr=5, WDSel=00 -> next edge wb_RFWe=1, wb_rfwaddr=5, wb_rfwdata=0x1234, mem_stall stays 0.
- Signed byte load: lb, addr=0x103, ack after 2 BUS cycles with rdata=0x80FF_0000 -> dm_addr=0x100, dm_we=0, mem_stall high 2 cycles, then wb_rfwdata=0xFFFF_FF80; lbu on the same access gives 0x0000_0080.
- Half store: sh, addr=0x22, rs2=0xDEAD_BEEF -> dm_be=1100, dm_wdata=0xBEEF_BEEF, dm_we=1; after ack wb_RFWe=0.
- Misaligned access: lw, addr=0x41 -> dm_req never asserts, mem_misalign pulses 1 cycle, wb_RFWe=0, no stall.
- Timeout: TIMEOUT=4, load with no ack -> dm_req high exactly 4 cycles, then mem_timeout pulses, wb_RFWe=0, state IDLE.
- Reset mid-access: reset=0 asserted asynchronously mid-cycle in BUS -> dm_req, mem_stall and all outputs go 0 immediately; after release, the next valid ALU op writes back normally.
